// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - pipeline stall/flush/forward sequencer with debug halt FSM
// Combinational hazard controls over registered RUN/HALT/STEP state and counters.
module hazard_control_unit #(
  parameter logic [7:0] MEM_TIMEOUT = 8'd15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RD_E,
  input  logic        ResultSrcE,
  input  logic        PCSrcE,
  input  logic [4:0]  RD_M,
  input  logic        RegWriteM,
  input  logic [4:0]  RDW,
  input  logic        RegWriteW,
  input  logic        MemReqM,
  input  logic        MemAckM,
  input  logic        HaltReq,
  input  logic        StepReq,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        Halted,
  output logic        MemErr,
  output logic [15:0] StallCnt
);

  typedef enum logic [1:0] {RUN, HALT, STEP} state_t;

  state_t      state_q, state_d;
  logic        halted_q, halted_d;
  logic        mem_err_q, mem_err_d;
  logic [7:0]  wait_q, wait_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        freeze;
  logic        load_use;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                         input logic wr_m, input logic [4:0] rd_w,
                                         input logic wr_w);
    if (wr_m && rd_m != 5'd0 && rd_m == rs)      return 2'b10;
    else if (wr_w && rd_w != 5'd0 && rd_w == rs) return 2'b01;
    else                                         return 2'b00;
  endfunction

  assign freeze   = MemReqM & ~MemAckM;
  assign load_use = ResultSrcE & (RD_E != 5'd0) & ((RD_E == Rs1D) | (RD_E == Rs2D));

  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    ForwardAE = fwd_sel(Rs1E, RD_M, RegWriteM, RDW, RegWriteW);
    ForwardBE = fwd_sel(Rs2E, RD_M, RegWriteM, RDW, RegWriteW);
    if (rst) begin
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
    end else if (freeze || state_q == HALT) begin
      // A taken branch seen while halted stays parked in E until released.
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (load_use) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = freeze ? ((wait_q == 8'hFF) ? wait_q : wait_q + 8'd1) : 8'd0;
    mem_err_d   = mem_err_q | (freeze & (wait_d == MEM_TIMEOUT));
    stall_cnt_d = (StallF && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    if (!freeze) begin
      case (state_q)
        RUN:     if (HaltReq) state_d = HALT;
        HALT:    if (StepReq) state_d = STEP;
                 else if (!HaltReq) state_d = RUN;
        STEP:    state_d = HALT;
        default: state_d = RUN;
      endcase
    end
    halted_d = (state_d == HALT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      halted_q    <= 1'b0;
      mem_err_q   <= 1'b0;
      wait_q      <= 8'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      halted_q    <= halted_d;
      mem_err_q   <= mem_err_d;
      wait_q      <= wait_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign Halted   = halted_q;
  assign MemErr   = mem_err_q;
  assign StallCnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - self-checking bench for hazard_control_unit
module tb_hazard_control_unit;
  localparam int TMO = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, ResultSrcE, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemAckM, HaltReq, StepReq;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RD_E, RD_M, RDW;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, Halted, MemErr;
  logic [1:0] ForwardAE, ForwardBE;
  logic [15:0] StallCnt;
  logic [9:0] dut_vec;
  assign dut_vec = {StallF, StallD, StallE, StallM, FlushD, FlushE, ForwardAE, ForwardBE};

  hazard_control_unit #(.MEM_TIMEOUT(8'd15)) dut (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RD_E(RD_E), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .RD_M(RD_M),
    .RegWriteM(RegWriteM), .RDW(RDW), .RegWriteW(RegWriteW), .MemReqM(MemReqM),
    .MemAckM(MemAckM), .HaltReq(HaltReq), .StepReq(StepReq), .StallF(StallF),
    .StallD(StallD), .StallE(StallE), .StallM(StallM), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .Halted(Halted), .MemErr(MemErr),
    .StallCnt(StallCnt)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: mode 0=run, 1=halted, 2=single step.
  int m_mode, m_wait, m_scnt;
  bit m_err;

  typedef struct {
    string      name;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rd_e;
    logic       ld, pcs;
    logic [4:0] rd_m;
    logic       rwm;
    logic [4:0] rdw;
    logic       rww, mreq, mack;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int fwd_of(input logic [4:0] rs);
    if (RegWriteM && RD_M != 0 && RD_M == rs) return 2;
    if (RegWriteW && RDW != 0 && RDW == rs) return 1;
    return 0;
  endfunction

  function automatic logic [9:0] model_comb();
    logic [3:0] st;
    logic [1:0] fl;
    bit frz, lu;
    if (rst) return 10'b0000_11_00_00;
    frz = MemReqM && !MemAckM;
    lu  = ResultSrcE && RD_E != 0 && (RD_E == Rs1D || RD_E == Rs2D);
    st = 4'b0000; fl = 2'b00;
    if (frz || m_mode == 1) st = 4'b1111;
    else if (PCSrcE)        fl = 2'b11;
    else if (lu) begin st = 4'b1100; fl = 2'b01; end
    return {st, fl, 2'(fwd_of(Rs1E)), 2'(fwd_of(Rs2E))};
  endfunction

  task automatic model_edge();
    logic [9:0] e;
    bit frz;
    e = model_comb();
    if (rst) begin
      m_mode = 0; m_wait = 0; m_scnt = 0; m_err = 0;
      return;
    end
    frz = MemReqM && !MemAckM;
    if (e[9] && m_scnt < 65535) m_scnt++;
    if (frz) begin
      if (m_wait < 255) m_wait++;
      if (m_wait == TMO) m_err = 1;
    end else begin
      m_wait = 0;
      case (m_mode)
        0: if (HaltReq) m_mode = 1;
        1: if (StepReq) m_mode = 2; else if (!HaltReq) m_mode = 0;
        default: m_mode = 1;
      endcase
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_ctl"}, 32'(dut_vec), 32'(model_comb()));
    chk({tag, "_halted"}, 32'(Halted), 32'(m_mode == 1));
    chk({tag, "_memerr"}, 32'(MemErr), 32'(m_err));
    chk({tag, "_stallcnt"}, 32'(StallCnt), 32'(m_scnt));
  endtask

  task automatic half();
    @(negedge clk);
  endtask

  task automatic fin();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    {Rs1D, Rs2D, Rs1E, Rs2E, RD_E, RD_M, RDW} = '0;
    {ResultSrcE, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemAckM, HaltReq, StepReq} = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    half();
    check_all("rst");
    fin();
    rst = 1'b0;
  endtask

  function automatic vec_t mk(input string n, input int r1d, input int r2d, input int r1e,
                              input int r2e, input int rde, input bit ld, input bit pcs,
                              input int rdm, input bit rwm, input int rdw, input bit rww,
                              input bit mreq, input bit mack, input logic [9:0] exp);
    vec_t v;
    v.name = n; v.rs1d = 5'(r1d); v.rs2d = 5'(r2d); v.rs1e = 5'(r1e); v.rs2e = 5'(r2e);
    v.rd_e = 5'(rde); v.ld = ld; v.pcs = pcs; v.rd_m = 5'(rdm); v.rwm = rwm;
    v.rdw = 5'(rdw); v.rww = rww; v.mreq = mreq; v.mack = mack; v.exp = exp;
    return v;
  endfunction

  initial begin
    vecs.push_back(mk("lu_rs1",  5, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 10'b1100_01_00_00));
    vecs.push_back(mk("lu_rs2",  0, 7, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 10'b1100_01_00_00));
    vecs.push_back(mk("lu_x0",   0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 10'b0000_00_00_00));
    vecs.push_back(mk("no_load", 5, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 10'b0000_00_00_00));
    vecs.push_back(mk("br_lu",   5, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 10'b0000_11_00_00));
    vecs.push_back(mk("fwd_m",   0, 0, 3, 0, 0, 0, 0, 3, 1, 3, 1, 0, 0, 10'b0000_00_10_00));
    vecs.push_back(mk("fwd_w",   0, 0, 3, 0, 0, 0, 0, 3, 0, 3, 1, 0, 0, 10'b0000_00_01_00));
    vecs.push_back(mk("fwd_x0",  0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 10'b0000_00_00_00));
    vecs.push_back(mk("fwd_ab",  0, 0, 4, 9, 0, 0, 0, 4, 1, 9, 1, 0, 0, 10'b0000_00_10_01));
    vecs.push_back(mk("freeze",  5, 0, 2, 0, 5, 1, 1, 2, 1, 0, 0, 1, 0, 10'b1111_00_10_00));
    vecs.push_back(mk("mem_ack", 5, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 1, 1, 10'b1100_01_00_00));

    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    m_mode = 0; m_wait = 0; m_scnt = 0; m_err = 0;
    half();
    chk("rst_ctl", 32'(dut_vec), 32'(10'b0000_11_00_00));
    chk("rst_halted", 32'(Halted), 0);
    chk("rst_memerr", 32'(MemErr), 0);
    chk("rst_stallcnt", 32'(StallCnt), 0);
    fin();
    rst = 1'b0;

    foreach (vecs[i]) begin
      Rs1D = vecs[i].rs1d; Rs2D = vecs[i].rs2d; Rs1E = vecs[i].rs1e; Rs2E = vecs[i].rs2e;
      RD_E = vecs[i].rd_e; ResultSrcE = vecs[i].ld; PCSrcE = vecs[i].pcs;
      RD_M = vecs[i].rd_m; RegWriteM = vecs[i].rwm; RDW = vecs[i].rdw;
      RegWriteW = vecs[i].rww; MemReqM = vecs[i].mreq; MemAckM = vecs[i].mack;
      half();
      chk(vecs[i].name, 32'(dut_vec), 32'(vecs[i].exp));
      fin();
    end
    clear_inputs();
    half();
    check_all("after_table");
    fin();

    // Long freeze: MemErr appears on the 16th frozen cycle and stays.
    do_reset();
    MemReqM = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      half();
      chk("frz_ctl", 32'(dut_vec[9:4]), 32'(6'b1111_00));
      chk("frz_memerr", 32'(MemErr), 32'(k >= 16));
      fin();
    end
    MemAckM = 1'b1;
    half();
    chk("frz_stallcnt", 32'(StallCnt), 20);
    chk("frz_err_sticky", 32'(MemErr), 1);
    chk("frz_release", 32'(StallF), 0);
    fin();
    clear_inputs();

    // Halt, branch held, single step, release.
    HaltReq = 1'b1;
    half(); fin();
    PCSrcE = 1'b1;
    half();
    chk("halt_halted", 32'(Halted), 1);
    chk("halt_ctl", 32'(dut_vec[9:4]), 32'(6'b1111_00));
    fin();
    PCSrcE = 1'b0;
    StepReq = 1'b1;
    half();
    chk("halt_stepreq_ctl", 32'(dut_vec[9:4]), 32'(6'b1111_00));
    fin();
    StepReq = 1'b0;
    half();
    chk("step_halted", 32'(Halted), 0);
    chk("step_ctl", 32'(dut_vec[9:4]), 32'(6'b0000_00));
    fin();
    half();
    chk("step_back_halted", 32'(Halted), 1);
    fin();
    HaltReq = 1'b0;
    half(); fin();
    half();
    chk("resume_halted", 32'(Halted), 0);
    check_all("resume");
    fin();

    // Reset while halted with MemErr still set.
    HaltReq = 1'b1;
    half(); fin();
    half();
    chk("pre_rst_halted", 32'(Halted), 1);
    chk("pre_rst_memerr", 32'(MemErr), 1);
    fin();
    rst = 1'b1;
    half();
    chk("rst_halt_ctl", 32'(dut_vec), 32'(10'b0000_11_00_00));
    fin();
    half();
    chk("rst_halt_halted", 32'(Halted), 0);
    chk("rst_halt_memerr", 32'(MemErr), 0);
    chk("rst_halt_stallcnt", 32'(StallCnt), 0);
    chk("rst_halt_flush", 32'({FlushD, FlushE}), 32'(2'b11));
    fin();
    rst = 1'b0;
    HaltReq = 1'b0;
    half();
    chk("post_rst_halted", 32'(Halted), 0);
    fin();

    // Randomized traffic against the model.
    begin
      bit burst;
      burst = 0;
      for (int n = 0; n < 4000; n++) begin
        if (n % 60 == 0) burst = ($urandom_range(0, 2) == 0);
        rst        = ($urandom_range(0, 299) == 0);
        Rs1D       = 5'($urandom_range(0, 3));
        Rs2D       = 5'($urandom_range(0, 3));
        Rs1E       = 5'($urandom_range(0, 3));
        Rs2E       = 5'($urandom_range(0, 3));
        RD_E       = 5'($urandom_range(0, 3));
        RD_M       = 5'($urandom_range(0, 3));
        RDW        = 5'($urandom_range(0, 3));
        ResultSrcE = 1'($urandom_range(0, 1));
        PCSrcE     = ($urandom_range(0, 3) == 0);
        RegWriteM  = 1'($urandom_range(0, 1));
        RegWriteW  = 1'($urandom_range(0, 1));
        MemReqM    = burst ? 1'b1 : 1'($urandom_range(0, 1));
        MemAckM    = burst ? ($urandom_range(0, 24) == 0) : 1'($urandom_range(0, 1));
        if ($urandom_range(0, 15) == 0) HaltReq = ~HaltReq;
        StepReq    = ($urandom_range(0, 3) == 0);
        half();
        check_all("rand");
        fin();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Central pipeline sequencer for the 5-stage RISC-V core. It produces per-stage stall and flush controls plus E-stage operand forwarding selects from the register fields of the D/E/M/W stages. It freezes the whole pipeline while the data memory has not acknowledged an M-stage access, and provides a debug halt/single-step state machine. It also keeps a saturating stall counter and a sticky memory-timeout flag.

## Interface
- MEM_TIMEOUT, 15, consecutive memory-freeze cycles after which MemErr sets (1..255)
- clk  in  1  core clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- Rs1D, Rs2D  in  5  source registers of instruction in Decode
- Rs1E, Rs2E  in  5  source registers of instruction in Execute
- RD_E  in  5  destination of instruction in Execute
- ResultSrcE  in  1  1 = instruction in Execute is a load
- PCSrcE  in  1  branch/jump taken, resolved in Execute
- RD_M, RegWriteM  in  5, 1  destination and write-enable in Memory
- RDW, RegWriteW  in  5, 1  destination and write-enable in Writeback
- MemReqM  in  1  M-stage instruction accesses data memory this cycle
- MemAckM  in  1  data memory completes the access this cycle
- HaltReq  in  1  debug halt request (level)
- StepReq  in  1  debug single-step request (sampled only in HALT)
- StallF, StallD, StallE, StallM  out  1  hold the PC / IF-ID / ID-EX / EX-MEM register
- FlushD, FlushE  out  1  clear IF-ID / ID-EX register to a bubble
- ForwardAE, ForwardBE  out  2  00 = register file, 01 = ResultW, 10 = ALU result from M
- Halted  out  1  FSM is in HALT
- MemErr  out  1  sticky memory timeout
- StallCnt  out  16  saturating count of cycles with StallF=1

## Operation
- FSM states are RUN, HALT and STEP. Reset state is RUN.
- Freeze condition: MemReqM & ~MemAckM. It is combinational and valid in any state.
  - Effect: StallF=StallD=StallE=StallM=1, FlushD=FlushE=0.
  - The FSM holds its state while frozen.
- Load-use hazard: ResultSrcE & (RD_E≠0) & (RD_E==Rs1D | RD_E==Rs2D).
  - Effect: StallF=StallD=1, FlushE=1.
- Branch: PCSrcE is handled by FlushD=FlushE=1.
  - If a load-use hazard occurs in the same cycle, the branch wins: StallF=StallD=0 and both flushes are 1.
- Priority: freeze > HALT > branch > load-use > normal.
- RUN state:
  - HaltReq=1 with no freeze → HALT on the next cycle.
  - Otherwise controls follow the hazard rules above.
- HALT state:
  - All four stalls are 1, flushes are 0, Halted=1.
  - A PCSrcE in E is held, not acted on.
  - Exits, in priority order:
    - StepReq=1 → STEP.
    - Else HaltReq=0 → RUN.
- STEP state:
  - Exactly one cycle with hazard rules applied as in RUN. Halted=0.
  - Returns to HALT unconditionally. A freeze during STEP extends STEP until the freeze clears.
- Forwarding applies to each of A/B independently:
  - 10 if RegWriteM & RD_M≠0 & RD_M==RsxE.
  - Else 01 if RegWriteW & RDW≠0 & RDW==RsxE.
  - Else 00.
  - M has priority over W. Forwarding is independent of stall/FSM state.
- Wait counter (8-bit):
  - Increments each freeze cycle and clears on any non-freeze cycle.
  - When it reaches MEM_TIMEOUT, MemErr sets. MemErr is cleared only by rst.
  - The freeze continues regardless of MemErr.
- StallCnt increments on every cycle with StallF=1, including freeze and HALT cycles. It saturates at 16'hFFFF.

## Timing
- Stall, flush and forward outputs are combinational from the inputs and the current state. Consumers act on them at the same clock edge.
- FSM, wait counter, MemErr and StallCnt are registered. Their updates are visible the cycle after the triggering edge.
- Halt latency: HaltReq high at edge N puts the FSM in HALT during cycle N+1.
- Step: StepReq at edge N gives STEP during cycle N+1 and HALT during cycle N+2, advancing exactly one instruction per stage.
- While rst=1:
  - All stalls are 0, FlushD=FlushE=1, ForwardAE=ForwardBE=00.
  - Halted=0, MemErr=0, StallCnt=0, wait counter=0.
- After rst, the FSM is in RUN from the first cycle with rst=0, including when reset is applied mid-freeze or mid-HALT.
- Register x0 never generates a hazard or a forward.

## Test plan
- Rs1D=5, RD_E=5, ResultSrcE=1 → StallF=StallD=FlushE=1 for one cycle; with RD_E=0 → no stall.
- Same load-use plus PCSrcE=1 → FlushD=FlushE=1, StallF=StallD=0.
- Rs1E=3, RD_M=3, RegWriteM=1, RDW=3, RegWriteW=1 → ForwardAE=10; with RegWriteM=0 → 01; with Rs1E=0 → 00.
- MemReqM=1, MemAckM=0 for 20 cycles (MEM_TIMEOUT=15):
  - All stalls stay 1.
  - MemErr rises on the cycle after the 15th freeze cycle and stays 1 after MemAckM=1.
  - StallCnt=20.
- HaltReq=1 → Halted=1 next cycle. Then:
  - StepReq pulse → exactly one cycle with stalls 0, then HALT again.
  - HaltReq=0 → RUN.
- rst=1 asserted during HALT with MemErr=1 → next cycle Halted=0, MemErr=0, StallCnt=0, FlushD=FlushE=1 while rst is held.
